// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and width helpers for the segmentation
// bounding-box block.
package seg_pkg;

    localparam int         H_DISP_DEF    = 640;
    localparam int         V_DISP_DEF    = 480;
    localparam logic [7:0] BOX_COLOR_DEF = 8'd128;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_LATCH  = 2'd2;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seg_xy_cnt.sv
// Raster position tracker: x/y of the current pixel derived from de and vsync,
// plus a flag telling whether that position lies inside the active window.
module seg_xy_cnt
    import seg_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int V_DISP = V_DISP_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        de,
    input  logic                        vsync,
    output logic [coord_w(H_DISP)-1:0]  x,
    output logic [coord_w(V_DISP)-1:0]  y,
    output logic                        in_range
);

    localparam int XW = coord_w(H_DISP);
    localparam int YW = coord_w(V_DISP);
    localparam logic [XW:0] X_LIM = (XW + 1)'(H_DISP);
    localparam logic [YW:0] Y_LIM = (YW + 1)'(V_DISP);

    // One extra bit so over-long lines/frames saturate at the limit instead of wrapping
    logic [XW:0] x_cnt;
    logic [YW:0] y_cnt;
    logic        de_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            de_q  <= 1'b0;
        end else begin
            de_q <= de;
            if (vsync) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else begin
                if (!de)
                    x_cnt <= '0;
                else if (x_cnt != X_LIM)
                    x_cnt <= x_cnt + 1'b1;
                if (de_q && !de && (y_cnt != Y_LIM))
                    y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    assign x        = x_cnt[XW-1:0];
    assign y        = y_cnt[YW-1:0];
    assign in_range = (x_cnt < X_LIM) && (y_cnt < Y_LIM);

endmodule

// File: rtl/seg_bbox.sv
// Per-frame foreground bounding box and pixel count, with the previous frame's
// box drawn onto the re-emitted pixel stream.
//   state     | meaning
//   ST_IDLE   | after reset, waiting for a vsync falling edge (full frame start)
//   ST_ACTIVE | accumulating foreground extents for the current frame
//   ST_LATCH  | one cycle after frame end; results valid, bbox_valid high
module seg_bbox
    import seg_pkg::*;
#(
    parameter int         H_DISP    = H_DISP_DEF,
    parameter int         V_DISP    = V_DISP_DEF,
    parameter logic [7:0] BOX_COLOR = BOX_COLOR_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 seg_hsync,
    input  logic                                 seg_vsync,
    input  logic [7:0]                           seg_data,
    input  logic                                 seg_de,
    output logic                                 box_hsync,
    output logic                                 box_vsync,
    output logic [7:0]                           box_data,
    output logic                                 box_de,
    output logic                                 bbox_valid,
    output logic                                 bbox_empty,
    output logic [coord_w(H_DISP)-1:0]           bbox_xmin,
    output logic [coord_w(H_DISP)-1:0]           bbox_xmax,
    output logic [coord_w(V_DISP)-1:0]           bbox_ymin,
    output logic [coord_w(V_DISP)-1:0]           bbox_ymax,
    output logic [count_w(H_DISP*V_DISP)-1:0]    bbox_count
);

    localparam int XW = coord_w(H_DISP);
    localparam int YW = coord_w(V_DISP);
    localparam int CW = count_w(H_DISP * V_DISP);
    localparam logic [XW-1:0] X_INIT = XW'(H_DISP - 1);
    localparam logic [YW-1:0] Y_INIT = YW'(V_DISP - 1);

    state_t        state;
    logic          vs_q;
    logic          vs_rise;
    logic          vs_fall;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          in_range;
    logic          hit;
    logic          ov_en;
    logic          on_box;

    logic [XW-1:0] acc_xmin, acc_xmax, nxt_xmin, nxt_xmax;
    logic [YW-1:0] acc_ymin, acc_ymax, nxt_ymin, nxt_ymax;
    logic [CW-1:0] acc_count, nxt_count;

    seg_xy_cnt #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_xy (
        .clk      (clk),
        .rst_n    (rst_n),
        .de       (seg_de),
        .vsync    (seg_vsync),
        .x        (x),
        .y        (y),
        .in_range (in_range)
    );

    assign vs_rise = seg_vsync & ~vs_q;
    assign vs_fall = ~seg_vsync & vs_q;
    assign hit     = seg_de && in_range && (seg_data != 8'd0);

    // Accumulator next values include the current pixel, so a pixel on the
    // frame-end cycle lands in the latched result.
    always_comb begin
        nxt_xmin  = (hit && (x < acc_xmin)) ? x : acc_xmin;
        nxt_xmax  = (hit && (x > acc_xmax)) ? x : acc_xmax;
        nxt_ymin  = (hit && (y < acc_ymin)) ? y : acc_ymin;
        nxt_ymax  = (hit && (y > acc_ymax)) ? y : acc_ymax;
        nxt_count = acc_count + CW'(hit);
    end

    // Latched bbox outputs double as the overlay rectangle for the next frame.
    always_comb begin
        on_box = 1'b0;
        if (ov_en && seg_de && in_range) begin
            if (((x == bbox_xmin) || (x == bbox_xmax)) && (y >= bbox_ymin) && (y <= bbox_ymax))
                on_box = 1'b1;
            if (((y == bbox_ymin) || (y == bbox_ymax)) && (x >= bbox_xmin) && (x <= bbox_xmax))
                on_box = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_hsync <= 1'b0;
            box_vsync <= 1'b0;
            box_data  <= 8'd0;
            box_de    <= 1'b0;
        end else begin
            box_hsync <= seg_hsync;
            box_vsync <= seg_vsync;
            box_de    <= seg_de;
            box_data  <= on_box ? BOX_COLOR : seg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vs_q       <= 1'b0;
            ov_en      <= 1'b0;
            bbox_empty <= 1'b1;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            bbox_count <= '0;
            acc_xmin   <= X_INIT;
            acc_xmax   <= '0;
            acc_ymin   <= Y_INIT;
            acc_ymax   <= '0;
            acc_count  <= '0;
        end else begin
            vs_q <= seg_vsync;
            case (state)
                ST_IDLE: begin
                    acc_xmin  <= X_INIT;
                    acc_xmax  <= '0;
                    acc_ymin  <= Y_INIT;
                    acc_ymax  <= '0;
                    acc_count <= '0;
                    if (vs_fall)
                        state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        state      <= ST_LATCH;
                        bbox_empty <= (nxt_count == '0);
                        ov_en      <= (nxt_count != '0);
                        bbox_count <= nxt_count;
                        if (nxt_count == '0) begin
                            bbox_xmin <= '0;
                            bbox_xmax <= '0;
                            bbox_ymin <= '0;
                            bbox_ymax <= '0;
                        end else begin
                            bbox_xmin <= nxt_xmin;
                            bbox_xmax <= nxt_xmax;
                            bbox_ymin <= nxt_ymin;
                            bbox_ymax <= nxt_ymax;
                        end
                        acc_xmin  <= X_INIT;
                        acc_xmax  <= '0;
                        acc_ymin  <= Y_INIT;
                        acc_ymax  <= '0;
                        acc_count <= '0;
                    end else begin
                        acc_xmin  <= nxt_xmin;
                        acc_xmax  <= nxt_xmax;
                        acc_ymin  <= nxt_ymin;
                        acc_ymax  <= nxt_ymax;
                        acc_count <= nxt_count;
                    end
                end
                ST_LATCH: begin
                    state     <= ST_ACTIVE;
                    acc_xmin  <= nxt_xmin;
                    acc_xmax  <= nxt_xmax;
                    acc_ymin  <= nxt_ymin;
                    acc_ymax  <= nxt_ymax;
                    acc_count <= nxt_count;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bbox_valid = (state == ST_LATCH);

endmodule

// File: tb/tb_seg_bbox.sv
// Directed bench for seg_bbox on an 8x4 raster, checked every cycle against a
// frame-level model of box extents and overlay.
module tb_seg_bbox;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seg_hsync, seg_vsync, seg_de;
    logic [7:0] seg_data;
    logic       box_hsync, box_vsync, box_de;
    logic [7:0] box_data;
    logic       bbox_valid, bbox_empty;
    logic [2:0] bbox_xmin, bbox_xmax;
    logic [1:0] bbox_ymin, bbox_ymax;
    logic [5:0] bbox_count;

    always #5 clk = ~clk;

    seg_bbox #(.H_DISP(8), .V_DISP(4), .BOX_COLOR(8'd128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_hsync  (seg_hsync),
        .seg_vsync  (seg_vsync),
        .seg_data   (seg_data),
        .seg_de     (seg_de),
        .box_hsync  (box_hsync),
        .box_vsync  (box_vsync),
        .box_data   (box_data),
        .box_de     (box_de),
        .bbox_valid (bbox_valid),
        .bbox_empty (bbox_empty),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .bbox_count (bbox_count)
    );

    typedef struct {
        int hs, vs, de, data, valid, empty, xmin, xmax, ymin, ymax, count;
    } exp_t;

    int   n_chk = 0, n_fail = 0, n_valid = 0, n128 = 0;
    exp_t exp_now, exp_pipe;

    // model state
    int   fx[$], fy[$];
    bit   armed, prev_vs, ov_on;
    int   bx0, bx1, by0, by1;
    int   m_empty, m_xmin, m_xmax, m_ymin, m_ymax, m_count;

    // stimulus state
    logic [7:0] pix [4][10];
    int         llen [4];
    bit         vs_level, rise_last;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{default: 0};
        e.empty = 1;
        return e;
    endfunction

    task automatic model_reset();
        fx.delete(); fy.delete();
        armed = 0; prev_vs = 0; ov_on = 0;
        bx0 = 0; bx1 = 0; by0 = 0; by1 = 0;
        m_empty = 1; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_count = 0;
        exp_now = reset_exp();
    endtask

    task automatic model_step(input logic hs, input logic vs, input logic de,
                              input logic [7:0] d, input int x, input int y);
        bit inr, ovh;
        int cnt, x0, x1, y0, y1;
        inr = de && (x < 8) && (y < 4);
        ovh = ov_on && inr &&
              ((((x == bx0) || (x == bx1)) && (y >= by0) && (y <= by1)) ||
               (((y == by0) || (y == by1)) && (x >= bx0) && (x <= bx1)));
        exp_now.hs = hs; exp_now.vs = vs; exp_now.de = de;
        exp_now.data = ovh ? 128 : int'(d);
        exp_now.valid = 0;
        if (armed && inr && d != 8'd0) begin
            fx.push_back(x); fy.push_back(y);
        end
        if (vs && !prev_vs && armed) begin
            cnt = fx.size();
            x0 = 7; x1 = 0; y0 = 3; y1 = 0;
            for (int i = 0; i < cnt; i++) begin
                if (fx[i] < x0) x0 = fx[i];
                if (fx[i] > x1) x1 = fx[i];
                if (fy[i] < y0) y0 = fy[i];
                if (fy[i] > y1) y1 = fy[i];
            end
            m_count = cnt;
            m_empty = (cnt == 0);
            m_xmin = cnt ? x0 : 0; m_xmax = cnt ? x1 : 0;
            m_ymin = cnt ? y0 : 0; m_ymax = cnt ? y1 : 0;
            ov_on = (cnt != 0);
            bx0 = m_xmin; bx1 = m_xmax; by0 = m_ymin; by1 = m_ymax;
            exp_now.valid = 1;
            fx.delete(); fy.delete();
        end
        if (!vs && prev_vs) armed = 1;
        prev_vs = vs;
        exp_now.empty = m_empty; exp_now.count = m_count;
        exp_now.xmin = m_xmin; exp_now.xmax = m_xmax;
        exp_now.ymin = m_ymin; exp_now.ymax = m_ymax;
    endtask

    always @(posedge clk) exp_pipe = exp_now;

    always @(negedge clk) begin
        exp_t e;
        e = rst_n ? exp_pipe : reset_exp();
        chk("box_hsync", box_hsync, e.hs);
        chk("box_vsync", box_vsync, e.vs);
        chk("box_de", box_de, e.de);
        chk("box_data", box_data, e.data);
        chk("bbox_valid", bbox_valid, e.valid);
        chk("bbox_empty", bbox_empty, e.empty);
        chk("bbox_xmin", bbox_xmin, e.xmin);
        chk("bbox_xmax", bbox_xmax, e.xmax);
        chk("bbox_ymin", bbox_ymin, e.ymin);
        chk("bbox_ymax", bbox_ymax, e.ymax);
        chk("bbox_count", bbox_count, e.count);
        if (rst_n && bbox_valid) n_valid++;
        if (rst_n && box_de && box_data == 8'd128) n128++;
    end

    task automatic cyc(input logic hs, input logic vs, input logic de,
                       input logic [7:0] d, input int x, input int y);
        @(posedge clk); #1;
        seg_hsync = hs; seg_vsync = vs; seg_de = de; seg_data = d;
        model_step(hs, vs, de, d, x, y);
    endtask

    task automatic set_frame();
        for (int r = 0; r < 4; r++) begin
            llen[r] = 8;
            for (int c = 0; c < 10; c++) pix[r][c] = 8'd0;
        end
    endtask

    task automatic line(input int yy);
        for (int xx = 0; xx < llen[yy]; xx++) begin
            if (rise_last && yy == 3 && xx == llen[yy] - 1) vs_level = 1;
            cyc(1'b0, vs_level, 1'b1, pix[yy][xx], xx, yy);
        end
        cyc(1'b0, vs_level, 1'b0, 8'd0, 0, yy);
        cyc(1'b1, vs_level, 1'b0, 8'd0, 0, yy);
        cyc(1'b0, vs_level, 1'b0, 8'd0, 0, yy);
    endtask

    task automatic vpulse();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'd0, 0, 0);
        vs_level = 0; rise_last = 0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'd0, 0, 0);
    endtask

    task automatic frame();
        for (int yy = 0; yy < 4; yy++) line(yy);
        vpulse();
    endtask

    task automatic chk_box(input string tag, input int e, input int x0, input int x1,
                           input int y0, input int y1, input int c);
        chk({tag, "_empty"}, bbox_empty, e);
        chk({tag, "_xmin"}, bbox_xmin, x0);
        chk({tag, "_xmax"}, bbox_xmax, x1);
        chk({tag, "_ymin"}, bbox_ymin, y0);
        chk({tag, "_ymax"}, bbox_ymax, y1);
        chk({tag, "_count"}, bbox_count, c);
    endtask

    initial begin
        int nv;
        rst_n = 1'b0;
        seg_hsync = 0; seg_vsync = 0; seg_de = 0; seg_data = 8'd0;
        vs_level = 0; rise_last = 0;
        model_reset();
        exp_pipe = exp_now;
        repeat (3) @(posedge clk);
        #1;
        chk_box("in_reset", 1, 0, 0, 0, 0, 0);
        chk("in_reset_valid", bbox_valid, 0);
        rst_n = 1'b1;

        // partial first frame: no report
        set_frame();
        pix[1][3] = 8'd255; pix[2][6] = 8'd255;
        line(1); line(2); vpulse();
        chk("partial_nvalid", n_valid, 0);
        chk_box("partial", 1, 0, 0, 0, 0, 0);

        // frame A: three foreground pixels
        set_frame();
        pix[1][2] = 8'd255; pix[1][5] = 8'd255; pix[3][3] = 8'd255;
        frame();
        chk("a_nvalid", n_valid, 1);
        chk_box("a", 0, 2, 5, 1, 3, 3);

        // frame B: empty, shows A's rectangle
        set_frame(); n128 = 0;
        frame();
        chk("b_overlay_px", n128, 10);
        chk_box("b", 1, 0, 0, 0, 0, 0);

        // frame C: single pixel, no overlay after empty frame
        set_frame(); n128 = 0;
        pix[0][7] = 8'd255;
        frame();
        chk("c_overlay_px", n128, 0);
        chk_box("c", 0, 7, 7, 0, 0, 1);

        // frame D: over-long line, pixels beyond H_DISP ignored
        set_frame(); n128 = 0;
        llen[2] = 10;
        pix[2][4] = 8'd255; pix[2][8] = 8'd255; pix[2][9] = 8'd255;
        frame();
        chk("d_overlay_px", n128, 1);
        chk_box("d", 0, 4, 4, 2, 2, 1);

        // frame E: foreground pixel on the vsync rising-edge cycle
        set_frame(); rise_last = 1;
        pix[0][1] = 8'd255; pix[3][7] = 8'd255;
        frame();
        chk("e_nvalid", n_valid, 5);
        chk_box("e", 0, 1, 7, 0, 3, 2);

        // mid-frame reset
        set_frame();
        pix[0][0] = 8'd255;
        line(0); line(1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        seg_hsync = 0; seg_vsync = 0; seg_de = 0; seg_data = 8'd0;
        vs_level = 0;
        model_reset();
        #1;
        chk_box("mid_rst", 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nv = n_valid;
        line(2); line(3); vpulse();
        chk("post_rst_nvalid", n_valid, nv);

        // frame G: first full frame after reset
        set_frame();
        pix[2][3] = 8'd255;
        frame();
        chk("g_nvalid", n_valid, nv + 1);
        chk_box("g", 0, 3, 3, 2, 2, 1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
